vga_frame_timer: RTL and testbench

Raster timing source for the poker display: generates the pixel coordinates (`DrawX`, `DrawY`) consumed by the screen renderer, plus one-hot screen-mode selects (`start_state`, `game_state`, `wait_state`) latched on frame boundaries. Also produces `hsync`, `vsync` and display-enable delayed to line up with the renderer's registered RGB. Sits between the game FSM / board clocking and the renderer, and drives the VGA/HDMI encoder.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_frame_timer_if.sv | 35 +++
 rtl/sync_delay_line.sv | 34 +++
 rtl/vga_frame_timer.sv | 139 +++++++++++++
 tb/tb_vga_frame_timer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame timer.
// Contents:
//   - default 640x480@60 timing constants and the coordinate width
//   - screen_mode_t: the active screen, decoded to one-hot outputs by the timer
//   - next_mode(): fixed-priority request arbitration (start > game > wait)
package vga_pkg;

    localparam int unsigned CNT_W         = 10;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;
    localparam int unsigned PIPE_DLY_DEF  = 2;

    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_GAME  = 2'd1,
        MODE_WAIT  = 2'd2
    } screen_mode_t;

    // No request pending keeps the current screen.
    function automatic screen_mode_t next_mode(input logic         start_req,
                                               input logic         game_req,
                                               input logic         wait_req,
                                               input screen_mode_t cur);
        if (start_req) begin
            return MODE_START;
        end else if (game_req) begin
            return MODE_GAME;
        end else if (wait_req) begin
            return MODE_WAIT;
        end
        return cur;
    endfunction

endpackage

// File: rtl/vga_frame_timer_if.sv
// Signal bundle between the game side (master) and the frame timer (slave).
// master drives: pix_en, start_req, game_req, wait_req
// slave drives : DrawX, DrawY, start_state, game_state, wait_state,
//                hsync, vsync, vid_de, frame_start, line_start
interface vga_frame_timer_if;
    import vga_pkg::*;

    logic             pix_en;
    logic             start_req;
    logic             game_req;
    logic             wait_req;
    logic [CNT_W-1:0] DrawX;
    logic [CNT_W-1:0] DrawY;
    logic             start_state;
    logic             game_state;
    logic             wait_state;
    logic             hsync;
    logic             vsync;
    logic             vid_de;
    logic             frame_start;
    logic             line_start;

    modport master (
        output pix_en, start_req, game_req, wait_req,
        input  DrawX, DrawY, start_state, game_state, wait_state,
        input  hsync, vsync, vid_de, frame_start, line_start
    );

    modport slave (
        input  pix_en, start_req, game_req, wait_req,
        output DrawX, DrawY, start_state, game_state, wait_state,
        output hsync, vsync, vid_de, frame_start, line_start
    );

endinterface

// File: rtl/sync_delay_line.sv
// Enable-gated shift register used to align sync/DE with the renderer pipeline.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift enable (pixel tick)
//   din        : undelayed bit
//   dout       : din delayed by DEPTH enabled ticks
// Parameters: DEPTH (>= 1), RST_VAL (inactive level loaded into every stage).
module sync_delay_line #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {DEPTH{RST_VAL}};
        end else if (en) begin
            sr_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_frame_timer.sv
// Raster timing source: pixel coordinates, delayed syncs/DE, line/frame pulses and
// one-hot screen-mode selects.
// Ports:
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : vga_frame_timer_if.slave (pix_en, mode requests in; coordinates,
//                mode selects, hsync/vsync/vid_de, frame_start/line_start out)
// Configuration macro VGA_MODE_FRAME_SYNC_EN:
//   defined   -> mode latches only on the (HT-1,VT-1)->(0,0) wrap tick
//   undefined -> mode follows the requests on every pixel tick (may tear mid-frame)
module vga_frame_timer
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter int unsigned PIPE_DLY  = PIPE_DLY_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_frame_timer_if.slave bus
);

    localparam int unsigned HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    screen_mode_t     mode_q, mode_d;
    logic             h_wrap, v_wrap;
    logic             hs_raw, vs_raw, de_raw;

    // Next-state logic
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        end

        // Pulses are recomputed every clk, so a held-off pix_en drops them after one clk.
        line_start_d  = bus.pix_en && h_wrap;
        frame_start_d = bus.pix_en && h_wrap && v_wrap;

`ifdef VGA_MODE_FRAME_SYNC_EN
        mode_d = frame_start_d ? next_mode(bus.start_req, bus.game_req, bus.wait_req, mode_q)
                               : mode_q;
`else
        mode_d = bus.pix_en ? next_mode(bus.start_req, bus.game_req, bus.wait_req, mode_q)
                            : mode_q;
`endif
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            mode_q        <= MODE_START;
        end else begin
            if (bus.pix_en) begin
                h_cnt_q <= h_cnt_d;
                v_cnt_q <= v_cnt_d;
            end
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            mode_q        <= mode_d;
        end
    end

    // Undelayed sync/DE for the coordinates currently presented on DrawX/DrawY
    always_comb begin
        hs_raw = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
        vs_raw = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
        de_raw = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    end

    sync_delay_line #(.DEPTH(PIPE_DLY), .RST_VAL(1'b1)) u_hsync_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.pix_en),
        .din  (hs_raw),
        .dout (bus.hsync)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .RST_VAL(1'b1)) u_vsync_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.pix_en),
        .din  (vs_raw),
        .dout (bus.vsync)
    );

    sync_delay_line #(.DEPTH(PIPE_DLY), .RST_VAL(1'b0)) u_de_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.pix_en),
        .din  (de_raw),
        .dout (bus.vid_de)
    );

    // Output decode; an illegal mode encoding falls back to the start screen so the
    // selects stay one-hot.
    always_comb begin
        bus.start_state = 1'b0;
        bus.game_state  = 1'b0;
        bus.wait_state  = 1'b0;
        case (mode_q)
            MODE_GAME: bus.game_state  = 1'b1;
            MODE_WAIT: bus.wait_state  = 1'b1;
            default:   bus.start_state = 1'b1;
        endcase
    end

    assign bus.DrawX       = h_cnt_q;
    assign bus.DrawY       = v_cnt_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Self-checking bench for vga_frame_timer. Uses a shrunken raster (32 x 19) so that
// several whole frames fit in a short run; the reference model derives every output
// from the number of pixel ticks since reset.
module tb_vga_frame_timer;
    import vga_pkg::*;

    localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int unsigned PD = 2;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_timer_if bus ();

    vga_frame_timer #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DLY (PD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: ticks since reset, selected screen, pulses from the last clk.
    int unsigned n;
    int          m_mode;
    bit          m_ls, m_fs;

    function automatic bit hs_at(input int unsigned k);
        int unsigned x = k % HT;
        return !(x >= HV + HF && x < HV + HF + HS);
    endfunction

    function automatic bit vs_at(input int unsigned k);
        int unsigned y = (k / HT) % VT;
        return !(y >= VV + VF && y < VV + VF + VS);
    endfunction

    function automatic bit de_at(input int unsigned k);
        return ((k % HT) < HV) && (((k / HT) % VT) < VV);
    endfunction

    task automatic model_reset();
        n      = 0;
        m_mode = 0;
        m_ls   = 0;
        m_fs   = 0;
    endtask

    task automatic apply_req(input bit s, input bit g, input bit w);
        if (s)      m_mode = 0;
        else if (g) m_mode = 1;
        else if (w) m_mode = 2;
    endtask

    task automatic model_step(input bit pen, input bit s, input bit g, input bit w);
        m_ls = 0;
        m_fs = 0;
        if (pen) begin
            n++;
            m_ls = (n % HT == 0);
            m_fs = (n % FT == 0);
`ifdef VGA_MODE_FRAME_SYNC_EN
            if (m_fs) apply_req(s, g, w);
`else
            apply_req(s, g, w);
`endif
        end
    endtask

    task automatic check_all();
        logic [2:0] exp_mode;
        exp_mode = (m_mode == 0) ? 3'b100 : (m_mode == 1) ? 3'b010 : 3'b001;
        check_eq("DrawX", 32'(bus.DrawX), n % HT);
        check_eq("DrawY", 32'(bus.DrawY), (n / HT) % VT);
        check_eq("hsync", 32'(bus.hsync), (n < PD) ? 32'd1 : 32'(hs_at(n - PD)));
        check_eq("vsync", 32'(bus.vsync), (n < PD) ? 32'd1 : 32'(vs_at(n - PD)));
        check_eq("vid_de", 32'(bus.vid_de), (n < PD) ? 32'd0 : 32'(de_at(n - PD)));
        check_eq("line_start", 32'(bus.line_start), 32'(m_ls));
        check_eq("frame_start", 32'(bus.frame_start), 32'(m_fs));
        check_eq("mode_onehot", 32'({bus.start_state, bus.game_state, bus.wait_state}),
                 32'(exp_mode));
    endtask

    // Called at a negedge: drive pix_en, let one posedge happen, then compare.
    task automatic cycle(input bit pen);
        bus.pix_en = pen;
        @(posedge clk);
        if (rst_n) model_step(pen, bus.start_req, bus.game_req, bus.wait_req);
        @(negedge clk);
        check_all();
    endtask

    // pen_mode: 0 = every clk, 1 = every other clk, 2 = random ~75 %
    task automatic run(input int cycles, input int pen_mode);
        for (int i = 0; i < cycles; i++) begin
            case (pen_mode)
                0:       cycle(1'b1);
                1:       cycle(i % 2 == 0);
                default: cycle($urandom_range(3) != 0);
            endcase
        end
    endtask

    // Tick until the model reaches (x, y), bounded by a few frames.
    task automatic run_to(input int unsigned x, input int unsigned y, input string tag);
        bit found = 0;
        for (int i = 0; i < 3 * FT && !found; i++) begin
            if ((n % HT) == x && ((n / HT) % VT) == y) found = 1;
            else cycle(1'b1);
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    initial begin
        bus.pix_en    = 1'b0;
        bus.start_req = 1'b0;
        bus.game_req  = 1'b0;
        bus.wait_req  = 1'b0;
        model_reset();

        // Reset state, with pix_en active while held in reset
        repeat (2) @(negedge clk);
        bus.pix_en = 1'b1;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // One full line plus a little: DrawX wraps, DrawY 0 -> 1, single line_start
        run(HT + 4, 0);
        // Half-rate pixel ticks
        run(4 * HT, 1);

        // game_req raised mid-frame and held: switch lands on the frame wrap
        run_to(0, 5, "reach_y5");
        bus.game_req = 1'b1;
        run(FT + 8, 0);
        bus.game_req = 1'b0;

        // wait_req pulsed and withdrawn well before the wrap
        run_to(3, 3, "reach_y3");
        bus.wait_req = 1'b1;
        run(3, 0);
        bus.wait_req = 1'b0;
        run(FT, 0);

        // Randomized ticks and requests over several frames
        for (int i = 0; i < 3 * FT; i++) begin
            if ($urandom_range(63) == 0) bus.start_req = ~bus.start_req;
            if ($urandom_range(47) == 0) bus.game_req  = ~bus.game_req;
            if ($urandom_range(47) == 0) bus.wait_req  = ~bus.wait_req;
            cycle($urandom_range(3) != 0);
        end
        bus.start_req = 1'b0;
        bus.wait_req  = 1'b0;
        bus.game_req  = 1'b1;
        run(2 * FT, 2);
        bus.game_req  = 1'b0;

        // Asynchronous reset in the middle of a frame
        run_to(10, 6, "reach_mid");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        run(3, 0);
        rst_n = 1'b1;
        run(FT + HT, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
